linear_sequencer: RTL and testbench

LINEAR_SEQUENCER -- requirements
Module: linear_sequencer

---
 rtl/linear_sequencer_pkg.sv | 8 +
 rtl/relu_vec.sv | 12 +
 rtl/linear_sequencer.sv | 131 +++++++++++++
 tb/tb_linear_sequencer.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/linear_sequencer_pkg.sv
// linear_sequencer_pkg: fp32 word, vector/matrix shapes and sequencer FSM states
package linear_sequencer_pkg;
    localparam int DEF_SIZE = 4;
    typedef logic [31:0] fp32_t;
    typedef fp32_t [DEF_SIZE-1:0] vec_t;
    typedef fp32_t [DEF_SIZE-1:0][DEF_SIZE-1:0] mat_t;
    typedef enum logic [2:0] {IDLE, LOAD, RUN, CAPTURE, CLEAR, FINISH} state_t;
endpackage

// File: rtl/relu_vec.sv
// relu_vec: sign-bit ReLU over a vector of fp32 words (negatives and -0.0 become +0.0)
// ports: x = input vector, y = clamped vector
module relu_vec import linear_sequencer_pkg::*; #(
    parameter int SIZE = 4
) (
    input  fp32_t [SIZE-1:0] x,
    output fp32_t [SIZE-1:0] y
);
    for (genvar i = 0; i < SIZE; i++) begin : g_el
        assign y[i] = x[i][31] ? '0 : x[i];
    end
endmodule

// File: rtl/linear_sequencer.sv
// linear_sequencer: chains up to MAX_LAYERS passes of an external linear engine,
// streaming each layer's weights from a 1-cycle-latency ROM and applying optional ReLU
// between passes.
// ports: clk/rst (async active-low); start/num_layers/relu_en/data_in = run request;
// busy/done/error/data_out = run status and result; w_rd_en/w_addr/w_rdata = weight ROM;
// eng_* = linear engine control, operands and result.
module linear_sequencer import linear_sequencer_pkg::*; #(
    parameter int SIZE       = 4,
    parameter int MAX_LAYERS = 8,
    parameter int TIMEOUT    = 1024,
    localparam int LW        = $clog2(MAX_LAYERS + 1),
    localparam int AW        = $clog2(MAX_LAYERS * SIZE * SIZE)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [LW-1:0]                 num_layers,
    input  logic                          relu_en,
    input  fp32_t [SIZE-1:0]              data_in,
    output logic                          busy,
    output logic                          done,
    output logic                          error,
    output fp32_t [SIZE-1:0]              data_out,
    output logic                          w_rd_en,
    output logic [AW-1:0]                 w_addr,
    input  fp32_t                         w_rdata,
    output logic                          eng_rst,
    output logic                          eng_enable,
    output fp32_t [SIZE-1:0]              eng_data_in,
    output fp32_t [SIZE-1:0][SIZE-1:0]    eng_weights,
    input  logic                          eng_done,
    input  fp32_t [SIZE-1:0]              eng_data_out
);
    localparam int N  = SIZE * SIZE;
    localparam int CW = $clog2(N + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t             state, next;
    logic [LW-1:0]      layer, nl;
    logic               relu;
    fp32_t [SIZE-1:0]   work, relu_out;
    fp32_t [N-1:0]      wts;
    logic [CW-1:0]      lcnt;
    logic [TW-1:0]      tcnt;
    logic               valid_start, last_pass, timeout;

    relu_vec #(.SIZE(SIZE)) u_relu (.x(eng_data_out), .y(relu_out));

    assign valid_start = start && num_layers != '0 && num_layers <= LW'(MAX_LAYERS);
    assign last_pass   = layer == nl - LW'(1);
    assign timeout     = tcnt == TW'(TIMEOUT - 1);
    assign done        = state == FINISH;
    assign eng_data_in = work;
    // flat row-major [in][out] storage maps directly onto the 2-D packed port
    assign eng_weights = wts;
    assign w_addr      = w_rd_en ? AW'(layer) * AW'(N) + AW'(lcnt) : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next;
    end

    always_comb begin
        next       = state;
        busy       = 1'b1;
        eng_rst    = 1'b0;
        eng_enable = 1'b0;
        w_rd_en    = 1'b0;
        case (state)
            IDLE: begin
                busy    = 1'b0;
                eng_rst = 1'b1;
                if (valid_start) next = LOAD;
            end
            // reads on lcnt 0..N-1, last word lands on lcnt N
            LOAD: begin
                w_rd_en = lcnt != CW'(N);
                if (lcnt == CW'(N)) next = RUN;
            end
            RUN: begin
                eng_enable = 1'b1;
                if (eng_done)     next = CAPTURE;
                else if (timeout) next = IDLE;
            end
            CAPTURE: next = CLEAR;
            // hold the engine in reset until its done flag has dropped
            CLEAR: begin
                eng_rst = 1'b1;
                if (!eng_done) next = layer < nl ? LOAD : FINISH;
            end
            FINISH: begin
                busy    = 1'b0;
                eng_rst = 1'b1;
                next    = IDLE;
            end
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            layer    <= '0;
            nl       <= '0;
            relu     <= 1'b0;
            work     <= '0;
            data_out <= '0;
            wts      <= '0;
            lcnt     <= '0;
            tcnt     <= '0;
            error    <= 1'b0;
        end else begin
            error <= (state == IDLE && start && !valid_start) || (state == RUN && !eng_done && timeout);
            lcnt  <= state == LOAD ? lcnt + CW'(1) : '0;
            tcnt  <= state == RUN ? tcnt + TW'(1) : '0;
            if (state == IDLE && valid_start) begin
                work  <= data_in;
                nl    <= num_layers;
                relu  <= relu_en;
                layer <= '0;
            end
            if (state == CAPTURE) begin
                work  <= relu && !last_pass ? relu_out : eng_data_out;
                layer <= layer + LW'(1);
            end
            // latched on entry so the result is valid alongside the done pulse
            if (next == FINISH) data_out <= work;
            for (int k = 0; k < N; k++)
                if (state == LOAD && lcnt == CW'(k + 1)) wts[k] <= w_rdata;
        end
    end
endmodule

// File: tb/tb_linear_sequencer.sv
// tb_linear_sequencer: scoreboard bench with a ROM model and a behavioural linear engine
module tb_linear_sequencer;
    import linear_sequencer_pkg::*;
    localparam int SIZE = 4, ML = 8, TO = 64, LAT = 5;
    localparam int LW = $clog2(ML + 1), AW = $clog2(ML * SIZE * SIZE), DEPTH = ML * SIZE * SIZE;
    localparam fp32_t ONE = 32'h3f800000, TWO = 32'h40000000, THREE = 32'h40400000, FOUR = 32'h40800000;
    localparam fp32_t HALF = 32'h3f000000, NHALF = 32'hbf000000, FIVE = 32'h40a00000;
    localparam fp32_t TEN = 32'h41200000, NTEN = 32'hc1200000, NTWENTY = 32'hc1a00000;

    logic clk = 0, rst = 0, start = 0, relu_en = 0;
    logic [LW-1:0] num_layers = '0;
    vec_t data_in = '0, data_out, eng_data_in;
    logic busy, done, error, w_rd_en, eng_rst, eng_enable;
    logic [AW-1:0] w_addr;
    fp32_t w_rdata = '0;
    mat_t eng_weights;
    logic eng_done = 0;
    vec_t eng_data_out = '0;
    bit eng_hang = 0;
    fp32_t rom [DEPTH];
    int hits [DEPTH];
    int rd_total = 0;
    int ecnt = 0;
    vec_t exp_q [$];
    int vectors = 0, miscompares = 0;
    vec_t in1234;

    linear_sequencer #(.SIZE(SIZE), .MAX_LAYERS(ML), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .num_layers(num_layers), .relu_en(relu_en),
        .data_in(data_in), .busy(busy), .done(done), .error(error), .data_out(data_out),
        .w_rd_en(w_rd_en), .w_addr(w_addr), .w_rdata(w_rdata), .eng_rst(eng_rst),
        .eng_enable(eng_enable), .eng_data_in(eng_data_in), .eng_weights(eng_weights),
        .eng_done(eng_done), .eng_data_out(eng_data_out)
    );

    always #5 clk = ~clk;

    function automatic real f2r(fp32_t b);
        real m;
        int e;
        if (b[30:0] == 0) return 0.0;
        m = 1.0 + real'(b[22:0]) / 8388608.0;
        e = int'(b[30:23]) - 127;
        while (e > 0) begin m = m * 2.0; e--; end
        while (e < 0) begin m = m / 2.0; e++; end
        return b[31] ? -m : m;
    endfunction

    function automatic fp32_t r2f(real v);
        real a;
        int e;
        logic [22:0] m;
        if (v == 0.0) return '0;
        a = v < 0.0 ? -v : v;
        e = 127;
        while (a >= 2.0) begin a = a / 2.0; e++; end
        while (a < 1.0) begin a = a * 2.0; e--; end
        m = 23'($rtoi((a - 1.0) * 8388608.0));
        return {v < 0.0, 8'(e), m};
    endfunction

    function automatic vec_t calc(vec_t x, mat_t w);
        vec_t r;
        real s;
        for (int j = 0; j < SIZE; j++) begin
            s = 0.0;
            for (int i = 0; i < SIZE; i++) s = s + f2r(x[i]) * f2r(w[i][j]);
            r[j] = r2f(s);
        end
        return r;
    endfunction

    always @(posedge clk) if (w_rd_en) begin
        w_rdata <= rom[w_addr];
        hits[w_addr] <= hits[w_addr] + 1;
        rd_total <= rd_total + 1;
    end

    // engine: done becomes visible on the LAT-th enabled cycle
    always @(posedge clk) begin
        if (eng_rst) begin
            ecnt <= 0;
            eng_done <= 0;
        end else if (eng_enable && !eng_done && !eng_hang) begin
            ecnt <= ecnt + 1;
            if (ecnt == LAT - 2) begin
                eng_done <= 1;
                eng_data_out <= calc(eng_data_in, eng_weights);
            end
        end
    end

    function automatic vec_t pop_exp();
        if (exp_q.size() == 0) return 'x;
        return exp_q.pop_front();
    endfunction

    task automatic fill(int layer, fp32_t v);
        for (int k = 0; k < SIZE * SIZE; k++) rom[layer * SIZE * SIZE + k] = v;
    endtask

    task automatic launch(int n, bit r, vec_t din);
        num_layers = LW'(n);
        relu_en = r;
        data_in = din;
        start = 1;
    endtask

    task automatic wait_end(output int cyc, output int busy_n);
        cyc = 0;
        busy_n = 0;
        do begin
            @(negedge clk);
            start = 0;
            cyc++;
            if (busy) busy_n++;
        end while (!done && !error && cyc < 4000);
    endtask

    task automatic test_reset();
        @(negedge clk);
        vectors++;
        if ({busy, done, error, w_rd_en, eng_enable, eng_rst} !== 6'b000001) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b want 000001", {busy, done, error, w_rd_en, eng_enable, eng_rst});
        end
        vectors++;
        if (w_addr !== '0) begin miscompares++; $display("FAIL reset_addr: got %h want 0", w_addr); end
        vectors++;
        if (data_out !== '0) begin miscompares++; $display("FAIL reset_data: got %h want 0", data_out); end
        vectors++;
        if (eng_weights !== '0) begin miscompares++; $display("FAIL reset_wts: got %h want 0", eng_weights); end
        rst = 1;
        @(negedge clk);
    endtask

    task automatic test_single_pass();
        int cyc, bn, rd0;
        vec_t e;
        fill(0, HALF);
        rd0 = rd_total;
        exp_q.push_back({4{FIVE}});
        launch(1, 0, in1234);
        wait_end(cyc, bn);
        e = pop_exp();
        vectors++;
        if (done !== 1'b1) begin miscompares++; $display("FAIL single_done: got %b want 1", done); end
        vectors++;
        if (data_out !== e) begin miscompares++; $display("FAIL single_data: got %h want %h", data_out, e); end
        vectors++;
        if (bn !== 17 + LAT + 3) begin miscompares++; $display("FAIL single_busy_len: got %0d want %0d", bn, 17 + LAT + 3); end
        vectors++;
        if (rd_total - rd0 !== 16) begin miscompares++; $display("FAIL single_reads: got %0d want 16", rd_total - rd0); end
        @(negedge clk);
        vectors++;
        if (done !== 1'b0) begin miscompares++; $display("FAIL single_done_pulse: got %b want 0", done); end
        vectors++;
        if (data_out !== e) begin miscompares++; $display("FAIL single_hold: got %h want %h", data_out, e); end
    endtask

    task automatic test_two_pass();
        int cyc, bn;
        vec_t e;
        fill(0, HALF);
        fill(1, NHALF);
        exp_q.push_back({4{NTEN}});
        launch(2, 1, in1234);
        wait_end(cyc, bn);
        e = pop_exp();
        vectors++;
        if (done !== 1'b1 || data_out !== e) begin
            miscompares++;
            $display("FAIL two_pass_neg: got done=%b %h want done=1 %h", done, data_out, e);
        end
        @(negedge clk);
        fill(1, HALF);
        exp_q.push_back({4{TEN}});
        launch(2, 1, in1234);
        wait_end(cyc, bn);
        e = pop_exp();
        vectors++;
        if (done !== 1'b1 || data_out !== e) begin
            miscompares++;
            $display("FAIL two_pass_pos: got done=%b %h want done=1 %h", done, data_out, e);
        end
        @(negedge clk);
    endtask

    task automatic test_relu_clamp();
        int cyc, bn, bad;
        int h0 [DEPTH];
        vec_t e;
        fill(0, NHALF);
        fill(1, ONE);
        h0 = hits;
        exp_q.push_back('0);
        launch(2, 1, in1234);
        wait_end(cyc, bn);
        e = pop_exp();
        vectors++;
        if (done !== 1'b1 || data_out !== e) begin
            miscompares++;
            $display("FAIL relu_clamp: got done=%b %h want done=1 %h", done, data_out, e);
        end
        bad = 0;
        for (int a = 0; a < DEPTH; a++) if (hits[a] - h0[a] != (a < 32 ? 1 : 0)) bad++;
        vectors++;
        if (bad !== 0) begin miscompares++; $display("FAIL relu_addr_span: got %0d bad addresses want 0", bad); end
        @(negedge clk);
        exp_q.push_back({4{NTWENTY}});
        launch(2, 0, in1234);
        wait_end(cyc, bn);
        e = pop_exp();
        vectors++;
        if (data_out !== e) begin miscompares++; $display("FAIL relu_off: got %h want %h", data_out, e); end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int cyc, bn;
        eng_hang = 1;
        fill(0, HALF);
        launch(1, 0, in1234);
        wait_end(cyc, bn);
        vectors++;
        if (error !== 1'b1 || done !== 1'b0) begin miscompares++; $display("FAIL timeout_err: got err=%b done=%b want 1/0", error, done); end
        vectors++;
        if (cyc !== 18 + TO) begin miscompares++; $display("FAIL timeout_time: got %0d want %0d", cyc, 18 + TO); end
        vectors++;
        if (busy !== 1'b0 || eng_rst !== 1'b1) begin miscompares++; $display("FAIL timeout_state: got busy=%b eng_rst=%b want 0/1", busy, eng_rst); end
        @(negedge clk);
        vectors++;
        if (error !== 1'b0) begin miscompares++; $display("FAIL timeout_pulse: got %b want 0", error); end
        eng_hang = 0;
    endtask

    task automatic test_invalid_layers();
        int bad [2] = '{0, ML + 1};
        int rd0;
        for (int i = 0; i < 2; i++) begin
            rd0 = rd_total;
            launch(bad[i], 0, in1234);
            @(negedge clk);
            start = 0;
            vectors++;
            if (error !== 1'b1 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL invalid_%0d: got err=%b busy=%b want 1/0", bad[i], error, busy);
            end
            @(negedge clk);
            vectors++;
            if (error !== 1'b0 || rd_total != rd0) begin
                miscompares++;
                $display("FAIL invalid_%0d_after: got err=%b reads=%0d want 0/0", bad[i], error, rd_total - rd0);
            end
        end
    endtask

    task automatic test_start_in_run();
        int n, cyc, bn, extra, rd0;
        vec_t e;
        fill(0, HALF);
        rd0 = rd_total;
        exp_q.push_back({4{FIVE}});
        launch(1, 0, in1234);
        n = 0;
        do begin @(negedge clk); start = 0; n++; end while (!eng_enable && n < 60);
        vectors++;
        if (eng_enable !== 1'b1) begin miscompares++; $display("FAIL run_reach: got %b want 1", eng_enable); end
        launch(1, 0, {4{ONE}});
        wait_end(cyc, bn);
        e = pop_exp();
        vectors++;
        if (done !== 1'b1 || data_out !== e) begin
            miscompares++;
            $display("FAIL run_start_ignored: got done=%b %h want done=1 %h", done, data_out, e);
        end
        extra = 0;
        repeat (30) begin @(negedge clk); if (busy) extra++; end
        vectors++;
        if (extra !== 0 || rd_total - rd0 !== 16) begin
            miscompares++;
            $display("FAIL run_no_rerun: got busy_cycles=%0d reads=%0d want 0/16", extra, rd_total - rd0);
        end
    endtask

    task automatic test_back_to_back();
        int cyc, bn;
        vec_t e;
        fill(0, HALF);
        exp_q.push_back({4{FIVE}});
        launch(1, 0, in1234);
        wait_end(cyc, bn);
        e = pop_exp();
        vectors++;
        if (done !== 1'b1 || data_out !== e) begin miscompares++; $display("FAIL b2b_first: got %h want %h", data_out, e); end
        launch(1, 0, {4{ONE}});
        @(negedge clk);
        start = 0;
        vectors++;
        if (busy !== 1'b0 || data_out !== e) begin
            miscompares++;
            $display("FAIL b2b_finish_start: got busy=%b %h want 0 %h", busy, data_out, e);
        end
        exp_q.push_back({4{FOUR}});
        launch(1, 0, {4{TWO}});
        wait_end(cyc, bn);
        e = pop_exp();
        vectors++;
        if (done !== 1'b1 || data_out !== e) begin miscompares++; $display("FAIL b2b_second: got %h want %h", data_out, e); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        int n, dones, cyc, bn;
        vec_t e;
        fill(0, HALF);
        fill(1, HALF);
        launch(2, 0, in1234);
        n = 0;
        do begin @(negedge clk); start = 0; n++; end while (!(w_rd_en && w_addr >= 16) && n < 200);
        vectors++;
        if (!(w_rd_en === 1'b1 && w_addr >= 16)) begin miscompares++; $display("FAIL mid_reach_layer1: got rd=%b addr=%0d", w_rd_en, w_addr); end
        rst = 0;
        #1;
        vectors++;
        if ({busy, done, error, w_rd_en, eng_enable, eng_rst} !== 6'b000001 || w_addr !== '0) begin
            miscompares++;
            $display("FAIL mid_reset_ctrl: got %b addr=%h want 000001 addr=0", {busy, done, error, w_rd_en, eng_enable, eng_rst}, w_addr);
        end
        vectors++;
        if (data_out !== '0 || eng_weights !== '0) begin
            miscompares++;
            $display("FAIL mid_reset_data: got %h / %h want 0", data_out, eng_weights);
        end
        repeat (2) @(negedge clk);
        rst = 1;
        dones = 0;
        repeat (40) begin @(negedge clk); if (done || error) dones++; end
        vectors++;
        if (dones !== 0) begin miscompares++; $display("FAIL mid_no_done: got %0d pulses want 0", dones); end
        exp_q.push_back({4{FIVE}});
        launch(1, 0, in1234);
        wait_end(cyc, bn);
        e = pop_exp();
        vectors++;
        if (done !== 1'b1 || data_out !== e) begin
            miscompares++;
            $display("FAIL mid_restart: got done=%b %h want done=1 %h", done, data_out, e);
        end
        @(negedge clk);
    endtask

    initial begin
        for (int a = 0; a < DEPTH; a++) begin rom[a] = '0; hits[a] = 0; end
        in1234 = {FOUR, THREE, TWO, ONE};
        test_reset();
        test_single_pass();
        test_two_pass();
        test_relu_clamp();
        test_timeout();
        test_invalid_layers();
        test_start_in_run();
        test_back_to_back();
        test_reset_mid_run();
        vectors++;
        if (exp_q.size() !== 0) begin miscompares++; $display("FAIL scoreboard_left: got %0d want 0", exp_q.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
